// File: rtl/multicore_boot_seq.sv
// rtl/multicore_boot_seq.sv - staggered multi-core reset release with optional per-core hang watchdog
// Optional watchdog is compiled in with MULTICORE_BOOT_SEQ_WATCHDOG_EN.
module multicore_boot_seq #(
    parameter int NUM_CORES      = 2,
    parameter int INIT_DELAY     = 16,
    parameter int STAGGER_CYCLES = 8,
    parameter int WDT_LIMIT      = 1024
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 restart_i,
    input  logic [NUM_CORES-1:0] core_active_i,
    output logic [NUM_CORES-1:0] core_rst_o,
    output logic                 all_released_o,
    output logic [NUM_CORES-1:0] core_hung_o,
    output logic                 hang_irq_o
);

    localparam int LAST_REL = INIT_DELAY + (NUM_CORES - 1) * STAGGER_CYCLES;
    localparam int SEQ_W    = $clog2(LAST_REL + 1);
    localparam logic [SEQ_W-1:0] SEQ_MAX   = SEQ_W'(LAST_REL);
    localparam logic [SEQ_W-1:0] FIRST_REL = SEQ_W'(INIT_DELAY);
    localparam bit DIRECT_RUN = (NUM_CORES == 1) || (STAGGER_CYCLES == 0);

    typedef enum logic [1:0] {
        S_INIT    = 2'd0,
        S_RELEASE = 2'd1,
        S_RUN     = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [SEQ_W-1:0]     seq_cnt_q, seq_cnt_d;
    logic [NUM_CORES-1:0] core_rst_q, core_rst_d;
    logic                 all_released_q, all_released_d;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q        <= S_INIT;
            seq_cnt_q      <= '0;
            core_rst_q     <= '1;
            all_released_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            seq_cnt_q      <= seq_cnt_d;
            core_rst_q     <= core_rst_d;
            all_released_q <= all_released_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (restart_i) begin
            state_d = S_INIT;
        end else begin
            case (state_q)
                S_INIT:    if (seq_cnt_q >= FIRST_REL) state_d = DIRECT_RUN ? S_RUN : S_RELEASE;
                S_RELEASE: if (seq_cnt_q >= SEQ_MAX) state_d = S_RUN;
                S_RUN:     state_d = S_RUN;
                default:   state_d = S_INIT;
            endcase
        end
    end

    // The sequence counter saturates at the last release point, so releases stay monotone.
    always_comb begin
        seq_cnt_d      = seq_cnt_q;
        core_rst_d     = core_rst_q;
        all_released_d = (state_d == S_RUN);
        if (restart_i) begin
            seq_cnt_d  = '0;
            core_rst_d = '1;
        end else begin
            if (seq_cnt_q != SEQ_MAX) seq_cnt_d = seq_cnt_q + SEQ_W'(1);
            for (int k = 0; k < NUM_CORES; k++) begin
                core_rst_d[k] = core_rst_q[k] &
                                (int'(seq_cnt_q) < INIT_DELAY + k * STAGGER_CYCLES);
            end
        end
    end

    assign core_rst_o     = core_rst_q;
    assign all_released_o = all_released_q;

`ifdef MULTICORE_BOOT_SEQ_WATCHDOG_EN
    localparam int WDT_W = $clog2(WDT_LIMIT + 1);
    localparam logic [WDT_W-1:0] WDT_MAX = WDT_W'(WDT_LIMIT);
    localparam logic [WDT_W-1:0] WDT_PRE = WDT_W'(WDT_LIMIT - 1);

    logic [NUM_CORES-1:0][WDT_W-1:0] wdt_q, wdt_d;
    logic [NUM_CORES-1:0]            hung_q, hung_d;
    logic                            irq_q, irq_d;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wdt_q  <= '0;
            hung_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            wdt_q  <= wdt_d;
            hung_q <= hung_d;
            irq_q  <= irq_d;
        end
    end

    // Activity in the final idle cycle wins over the hang flag.
    always_comb begin
        wdt_d  = wdt_q;
        hung_d = hung_q;
        irq_d  = |hung_q;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (restart_i) begin
                wdt_d[k]  = '0;
                hung_d[k] = 1'b0;
            end else if (core_rst_q[k] || core_active_i[k]) begin
                wdt_d[k] = '0;
            end else if (wdt_q[k] != WDT_MAX) begin
                wdt_d[k] = wdt_q[k] + WDT_W'(1);
                if (wdt_q[k] == WDT_PRE) hung_d[k] = 1'b1;
            end
        end
    end

    assign core_hung_o = hung_q;
    assign hang_irq_o  = irq_q;
`else
    logic unused_core_active;
    assign unused_core_active = ^core_active_i;
    assign core_hung_o        = '0;
    assign hang_irq_o         = 1'b0;
`endif

endmodule
